// File: rtl/uart_loader_pkg.sv
// rtl/uart_loader_pkg.sv - shared encodings and state type for the UART program loader
package uart_loader_pkg;

    // Encodings presented on the mode output
    localparam logic [2:0] MODE_IDLE = 3'd0;
    localparam logic [2:0] MODE_LOAD = 3'd1;
    localparam logic [2:0] MODE_EXEC = 3'd2;

    // Byte sent to the host to request a program image
    localparam logic [7:0] LOAD_REQ_BYTE = 8'hAA;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_SEND_AA   = 3'd1,
        ST_RECV_LEN  = 3'd2,
        ST_RECV_WORD = 3'd3,
        ST_EXEC      = 3'd4,
        ST_ERR       = 3'd5
    } loader_state_e;

endpackage

// File: rtl/uart_loader_assembler.sv
// rtl/uart_loader_assembler.sv - big-endian byte-to-word assembler with clear
module word_assembler (
    input  logic        clk,
    input  logic        rstn,
    input  logic        clear_i,
    input  logic [7:0]  byte_i,
    input  logic        valid_i,
    output logic [31:0] word_o,
    output logic        done_o
);

    // First three bytes of the word in arrival order; the fourth is taken live
    logic [23:0] shift_q;
    logic [1:0]  cnt_q;

    // The completed word is offered combinationally in the cycle of its last byte,
    // so the consumer can register it and write exactly one cycle later.
    assign word_o = {shift_q, byte_i};
    assign done_o = valid_i && !clear_i && (cnt_q == 2'd3);

    // Shift accepted bytes in and count them modulo four; clear drops a partial word
    always_ff @(posedge clk) begin
        if (!rstn || clear_i) begin
            shift_q <= 24'd0;
            cnt_q   <= 2'd0;
        end else if (valid_i) begin
            shift_q <= {shift_q[15:0], byte_i};
            cnt_q   <= cnt_q + 2'd1;
        end
    end

endmodule

// File: rtl/uart_loader.sv
// rtl/uart_loader.sv - UART handshake and program loader into external instruction memory
module uart_loader #(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              go,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_din,
    output logic [2:0]        mode,
    output logic              exec_start,
    output logic              err
);

    import uart_loader_pkg::*;

    // One past the highest word address; an announced length equal to this is legal
    localparam logic [32:0] CAPACITY = 33'd1 << ADDR_W;

    loader_state_e     state_q;
    logic [ADDR_W-1:0] word_cnt_q;
    logic [ADDR_W-1:0] last_q;
    logic [7:0]        tx_data_q;
    logic              tx_valid_q;
    logic              imem_we_q;
    logic [ADDR_W-1:0] imem_addr_q;
    logic [31:0]       imem_din_q;
    logic [2:0]        mode_q;
    logic              exec_start_q;
    logic              err_q;

    logic              receiving;
    logic              asm_valid;
    logic              asm_clear;
    logic [31:0]       asm_word;
    logic              asm_done;
    logic              len_zero;
    logic              len_too_long;
    logic [ADDR_W-1:0] last_d;

    // Bytes count only while a length or data word is expected
    assign receiving = (state_q == ST_RECV_LEN) || (state_q == ST_RECV_WORD);
    assign asm_valid = rx_valid && receiving;
    assign asm_clear = !receiving;

    word_assembler u_asm (
        .clk     (clk),
        .rstn    (rstn),
        .clear_i (asm_clear),
        .byte_i  (rx_data),
        .valid_i (asm_valid),
        .word_o  (asm_word),
        .done_o  (asm_done)
    );

    // Length decode: compare in 33 bits so every 32-bit length is judged correctly.
    // When the length equals capacity its low bits are zero and the subtraction
    // wraps to the top address, which is exactly the last index wanted.
    assign len_zero     = (asm_word == 32'd0);
    assign len_too_long = ({1'b0, asm_word} > CAPACITY);
    assign last_d       = asm_word[ADDR_W-1:0] - {{(ADDR_W-1){1'b0}}, 1'b1};

    // Loader FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q      <= ST_IDLE;
            word_cnt_q   <= '0;
            last_q       <= '0;
            tx_data_q    <= 8'd0;
            tx_valid_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_din_q   <= 32'd0;
            mode_q       <= MODE_IDLE;
            exec_start_q <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            imem_we_q    <= 1'b0;
            exec_start_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (go) begin
                        state_q    <= ST_SEND_AA;
                        mode_q     <= MODE_LOAD;
                        tx_valid_q <= 1'b1;
                        tx_data_q  <= LOAD_REQ_BYTE;
                    end
                end
                ST_SEND_AA: begin
                    if (tx_ready) begin
                        state_q    <= ST_RECV_LEN;
                        tx_valid_q <= 1'b0;
                        tx_data_q  <= 8'd0;
                    end
                end
                ST_RECV_LEN: begin
                    if (asm_done) begin
                        if (len_zero) begin
                            state_q      <= ST_EXEC;
                            mode_q       <= MODE_EXEC;
                            exec_start_q <= 1'b1;
                        end else if (len_too_long) begin
                            state_q <= ST_ERR;
                            mode_q  <= MODE_IDLE;
                            err_q   <= 1'b1;
                        end else begin
                            state_q    <= ST_RECV_WORD;
                            word_cnt_q <= '0;
                            last_q     <= last_d;
                        end
                    end
                end
                ST_RECV_WORD: begin
                    if (asm_done) begin
                        imem_we_q   <= 1'b1;
                        imem_addr_q <= word_cnt_q;
                        imem_din_q  <= asm_word;
                        word_cnt_q  <= word_cnt_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                        if (word_cnt_q == last_q) begin
                            state_q      <= ST_EXEC;
                            mode_q       <= MODE_EXEC;
                            exec_start_q <= 1'b1;
                        end
                    end
                end
                ST_EXEC: begin
                    state_q <= ST_EXEC;
                end
                ST_ERR: begin
                    state_q <= ST_ERR;
                end
                default: begin
                    state_q <= ST_IDLE;
                    mode_q  <= MODE_IDLE;
                end
            endcase
        end
    end

    assign tx_data    = tx_data_q;
    assign tx_valid   = tx_valid_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_din   = imem_din_q;
    assign mode       = mode_q;
    assign exec_start = exec_start_q;
    assign err        = err_q;

endmodule

// File: tb/tb_uart_loader.sv
// tb/tb_uart_loader.sv - self-checking bench for uart_loader (ADDR_W=4)
module tb_uart_loader;

    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          rstn = 1'b0;
    logic          go = 1'b0;
    logic [7:0]    rx_data = 8'd0;
    logic          rx_valid = 1'b0;
    logic          tx_ready = 1'b0;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          imem_we;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_din;
    logic [2:0]    mode;
    logic          exec_start;
    logic          err;

    uart_loader #(.ADDR_W(AW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .go         (go),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .imem_we    (imem_we),
        .imem_addr  (imem_addr),
        .imem_din   (imem_din),
        .mode       (mode),
        .exec_start (exec_start),
        .err        (err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Event counters, sampled on the falling edge
    int            wr_cnt = 0;
    int            ex_cnt = 0;
    int            hs_cnt = 0;
    int            txaa_cnt = 0;
    logic [AW-1:0] wr_addr_q[$];
    logic [31:0]   wr_data_q[$];

    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            wr_cnt++;
            wr_addr_q.push_back(imem_addr);
            wr_data_q.push_back(imem_din);
        end
        if (exec_start === 1'b1) ex_cnt++;
        if (tx_valid === 1'b1 && tx_ready === 1'b1) hs_cnt++;
        if (tx_valid === 1'b1 && tx_data === 8'hAA) txaa_cnt++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got running expected finished");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_valid = 1'b1;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) send_byte(w[31-8*i -: 8]);
    endtask

    task automatic do_reset();
        rstn = 1'b0; go = 1'b0; rx_valid = 1'b0; tx_ready = 1'b0;
        step();
        step();
        rstn = 1'b1;
    endtask

    task automatic start_load();
        go = 1'b1;
        step();
        go = 1'b0;
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_mode"}, mode, 3'd0);
        check({tag, "_tx_valid"}, tx_valid, 1'b0);
        check({tag, "_tx_data"}, tx_data, 8'd0);
        check({tag, "_imem_we"}, imem_we, 1'b0);
        check({tag, "_imem_addr"}, imem_addr, 4'd0);
        check({tag, "_imem_din"}, imem_din, 32'd0);
        check({tag, "_exec_start"}, exec_start, 1'b0);
        check({tag, "_err"}, err, 1'b0);
    endtask

    function automatic logic [31:0] word_of(int k, logic [31:0] w0, logic [31:0] w1);
        if (k == 0) return w0;
        if (k == 1) return w1;
        return 32'h1F2E3D4C ^ (32'(k) * 32'h01010101);
    endfunction

    typedef struct {
        logic [31:0] len;
        logic [31:0] w0;
        logic [31:0] w1;
        logic        exp_err;
        logic [2:0]  exp_mode;
        int          exp_writes;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int base_w, base_e, base_h, base_a, bad, n;
        logic [31:0] wv;

        vecs[0] = '{32'h00000002, 32'h3C010001, 32'h00000020, 1'b0, 3'd2, 2};
        vecs[1] = '{32'h00000000, 32'h0,        32'h0,        1'b0, 3'd2, 0};
        vecs[2] = '{32'h00000011, 32'h0,        32'h0,        1'b1, 3'd0, 0};
        vecs[3] = '{32'h00000010, 32'h11111111, 32'h22222222, 1'b0, 3'd2, 16};
        vecs[4] = '{32'h00000003, 32'hCAFEF00D, 32'h0BADBEEF, 1'b0, 3'd2, 3};
        vecs[5] = '{32'hFFFFFFFF, 32'h0,        32'h0,        1'b1, 3'd0, 0};
        vecs[6] = '{32'h00000100, 32'h0,        32'h0,        1'b1, 3'd0, 0};
        vecs[7] = '{32'h00000001, 32'hDEADBEEF, 32'h0,        1'b0, 3'd2, 1};

        // Reset state, and IDLE ignores incoming bytes
        rstn = 1'b0;
        step();
        step();
        check_all_zero("reset");
        rstn = 1'b1;
        send_byte(8'h55);
        send_byte(8'h66);
        check_all_zero("idle_rx");

        // Table of complete load scenarios
        for (int i = 0; i < 8; i++) begin
            do_reset();
            base_w = wr_cnt;
            base_e = ex_cnt;
            start_load();
            send_word(vecs[i].len);
            check($sformatf("v%0d_mode_after_len", i), mode,
                  vecs[i].exp_err ? 3'd0 : (vecs[i].exp_writes == 0 ? 3'd2 : 3'd1));
            check($sformatf("v%0d_err_after_len", i), err, vecs[i].exp_err);
            bad = 0;
            for (int k = 0; k < vecs[i].exp_writes; k++) begin
                wv = word_of(k, vecs[i].w0, vecs[i].w1);
                send_word(wv);
                if (imem_we !== 1'b1 || imem_addr !== AW'(k) || imem_din !== wv) bad++;
                if (k == vecs[i].exp_writes - 1) begin
                    check($sformatf("v%0d_mode_on_last_write", i), mode, 3'd2);
                    check($sformatf("v%0d_exec_start_on_last_write", i), exec_start, 1'b1);
                end
            end
            check($sformatf("v%0d_write_timing", i), bad, 0);
            step();
            go = 1'b1;
            step();
            go = 1'b0;
            send_word(32'h12345678);
            step();
            check($sformatf("v%0d_mode_final", i), mode, vecs[i].exp_mode);
            check($sformatf("v%0d_err_final", i), err, vecs[i].exp_err);
            check($sformatf("v%0d_write_count", i), wr_cnt - base_w, vecs[i].exp_writes);
            check($sformatf("v%0d_exec_pulses", i), ex_cnt - base_e, (vecs[i].exp_mode == 3'd2) ? 1 : 0);
            check($sformatf("v%0d_we_idle", i), imem_we, 1'b0);
            check($sformatf("v%0d_tx_valid", i), tx_valid, 1'b0);
            n = wr_cnt - base_w;
            bad = 0;
            for (int k = 0; k < vecs[i].exp_writes && k < n; k++) begin
                if (wr_addr_q[base_w + k] !== AW'(k) ||
                    wr_data_q[base_w + k] !== word_of(k, vecs[i].w0, vecs[i].w1)) bad++;
            end
            check($sformatf("v%0d_write_contents", i), bad, 0);
            check($sformatf("v%0d_addr_hold", i), imem_addr,
                  vecs[i].exp_writes > 0 ? 32'(vecs[i].exp_writes - 1) : 32'd0);
            check($sformatf("v%0d_din_hold", i), imem_din,
                  vecs[i].exp_writes > 0 ? word_of(vecs[i].exp_writes - 1, vecs[i].w0, vecs[i].w1) : 32'd0);
        end

        // Request byte held under back-pressure: five cycles not ready, then accepted
        do_reset();
        base_h = hs_cnt;
        base_a = txaa_cnt;
        go = 1'b1;
        step();
        go = 1'b0;
        bad = 0;
        for (int c = 0; c < 5; c++) begin
            if (tx_valid !== 1'b1 || tx_data !== 8'hAA || mode !== 3'd1) bad++;
            step();
        end
        if (tx_valid !== 1'b1 || tx_data !== 8'hAA || mode !== 3'd1) bad++;
        tx_ready = 1'b1;
        step();
        check("bp_held_cycles", bad, 0);
        check("bp_tx_valid_drop", tx_valid, 1'b0);
        check("bp_mode_load", mode, 3'd1);
        step();
        step();
        tx_ready = 1'b0;
        check("bp_handshakes", hs_cnt - base_h, 1);
        check("bp_aa_cycles", txaa_cnt - base_a, 6);

        // Reset in the middle of a word, then a fresh load
        do_reset();
        start_load();
        send_word(32'h00000002);
        send_word(32'hA1B2C3D4);
        send_byte(8'h11);
        send_byte(8'h22);
        rstn = 1'b0;
        step();
        check_all_zero("midreset");
        rstn = 1'b1;
        base_w = wr_cnt;
        step();
        start_load();
        send_word(32'h00000001);
        send_word(32'hDEADBEEF);
        step();
        check("midreset_writes", wr_cnt - base_w, 1);
        check("midreset_addr", (wr_cnt - base_w == 1) ? 32'(wr_addr_q[base_w]) : 32'hFFFFFFFF, 32'd0);
        check("midreset_data", (wr_cnt - base_w == 1) ? wr_data_q[base_w] : 32'hFFFFFFFF, 32'hDEADBEEF);
        check("midreset_mode", mode, 3'd2);

        // Stray go and bytes in states that must ignore them
        do_reset();
        base_w = wr_cnt;
        base_e = ex_cnt;
        base_h = hs_cnt;
        go = 1'b1;
        step();
        go = 1'b0;
        send_byte(8'h01);
        send_byte(8'h02);
        send_byte(8'h03);
        rx_data = 8'h04;
        rx_valid = 1'b1;
        tx_ready = 1'b1;
        step();
        rx_valid = 1'b0;
        tx_ready = 1'b0;
        send_word(32'h00000002);
        send_byte(8'h3C);
        send_byte(8'h01);
        go = 1'b1;
        step();
        go = 1'b0;
        send_byte(8'h00);
        go = 1'b1;
        send_byte(8'h01);
        go = 1'b0;
        send_word(32'h00000020);
        go = 1'b1;
        send_byte(8'hAA);
        go = 1'b0;
        send_word(32'h00000005);
        step();
        check("stray_writes", wr_cnt - base_w, 2);
        check("stray_w0", (wr_cnt - base_w >= 1) ? wr_data_q[base_w] : 32'hFFFFFFFF, 32'h3C010001);
        check("stray_w1", (wr_cnt - base_w >= 2) ? wr_data_q[base_w + 1] : 32'hFFFFFFFF, 32'h00000020);
        check("stray_a1", (wr_cnt - base_w >= 2) ? 32'(wr_addr_q[base_w + 1]) : 32'hFFFFFFFF, 32'd1);
        check("stray_mode", mode, 3'd2);
        check("stray_exec_pulses", ex_cnt - base_e, 1);
        check("stray_handshakes", hs_cnt - base_h, 1);
        check("stray_addr_hold", imem_addr, 4'd1);
        check("stray_din_hold", imem_din, 32'h00000020);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
